// File: rtl/jtframe_nvram_pkg.sv
// jtframe_nvram_pkg: shared FSM encoding and address
// range helper for the NVRAM ioctl port driver.
package jtframe_nvram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_CAP  = 2'd3
  } nv_state_t;

  function automatic logic in_range(
    input logic [63:0] addr,
    input int          aw
  );
    return (addr >> aw) == 64'd0;
  endfunction

endpackage

// File: rtl/jtframe_nvram_ioctl.sv
// jtframe_nvram_ioctl: drives NVRAM port 1 from the
// ioctl download/upload window and tracks a dirty flag.
module jtframe_nvram_ioctl
  import jtframe_nvram_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 10,
  parameter int IOW   = 25,
  parameter int RDLAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ioctl_ram,
  input  logic [IOW-1:0] ioctl_addr,
  input  logic [DW-1:0]  ioctl_dout,
  input  logic           ioctl_wr,
  input  logic           ioctl_rd,
  output logic [DW-1:0]  ioctl_din,
  output logic           ioctl_din_ok,
  input  logic           game_we,
  output logic           dirty,
  output logic           busy,
  output logic           sel_b,
  output logic [AW-1:0]  addr1b,
  output logic           we_b,
  output logic [DW-1:0]  data1,
  input  logic [DW-1:0]  q1
);

  localparam logic [1:0] CNT_INIT = 2'(RDLAT - 1);

  nv_state_t     state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] din_q, din_d;
  logic          we_q, we_d;
  logic          ok_q, ok_d;
  logic          sel_q, sel_d;
  logic          dirty_q, dirty_d;
  logic          inr_q, inr_d;
  logic          acc_q, acc_d;
  logic          ram_q, ram_d;

  logic idle, addr_ok, take_wr, take_rd, fall;

  always_comb begin
    idle    = state_q == ST_IDLE;
    addr_ok = in_range(64'(ioctl_addr), AW);
    take_wr = idle & ioctl_ram & ioctl_wr;
    take_rd = idle & ioctl_ram & ioctl_rd & ~ioctl_wr;
    fall    = ram_q & ~ioctl_ram;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    din_d   = din_q;
    inr_d   = inr_q;
    we_d    = 1'b0;
    ok_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (take_wr) begin
          state_d = ST_WR;
          addr_d  = ioctl_addr[AW-1:0];
          data_d  = ioctl_dout;
          we_d    = addr_ok;
        end else if (take_rd) begin
          state_d = ST_RD;
          addr_d  = ioctl_addr[AW-1:0];
          cnt_d   = CNT_INIT;
          inr_d   = addr_ok;
        end
      end
      ST_WR: state_d = ST_IDLE;
      ST_RD: begin
        if (cnt_q == 2'd0) state_d = ST_CAP;
        else cnt_d = cnt_q - 2'd1;
      end
      ST_CAP: begin
        state_d = ST_IDLE;
        ok_d    = 1'b1;
        din_d   = inr_q ? q1 : '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // sel_b stays up while busy so a read in flight at
  // window close still completes on port 1
  always_comb begin
    sel_d   = ioctl_ram | ~idle;
    ram_d   = ioctl_ram;
    acc_d   = fall ? 1'b0 : (acc_q | take_wr | take_rd);
    dirty_d = dirty_q;
    if (fall && acc_q) dirty_d = 1'b0;
    if (game_we) dirty_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      din_q   <= '0;
      inr_q   <= 1'b0;
      we_q    <= 1'b0;
      ok_q    <= 1'b0;
      sel_q   <= 1'b0;
      dirty_q <= 1'b0;
      acc_q   <= 1'b0;
      ram_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      din_q   <= din_d;
      inr_q   <= inr_d;
      we_q    <= we_d;
      ok_q    <= ok_d;
      sel_q   <= sel_d;
      dirty_q <= dirty_d;
      acc_q   <= acc_d;
      ram_q   <= ram_d;
    end
  end

  assign ioctl_din    = din_q;
  assign ioctl_din_ok = ok_q;
  assign dirty        = dirty_q;
  assign busy         = ~idle;
  assign sel_b        = sel_q;
  assign addr1b       = addr_q;
  assign we_b         = we_q;
  assign data1        = data_q;

endmodule

// File: tb/tb_jtframe_nvram_ioctl.sv
// tb_jtframe_nvram_ioctl: scoreboard bench with an NVRAM
// model and a transaction-level reference of the ioctl port.
module tb_jtframe_nvram_ioctl;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int IOW   = 25;
  localparam int RDLAT = 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ioctl_ram = 1'b0;
  logic [IOW-1:0] ioctl_addr = '0;
  logic [DW-1:0]  ioctl_dout = '0;
  logic           ioctl_wr = 1'b0;
  logic           ioctl_rd = 1'b0;
  logic [DW-1:0]  ioctl_din;
  logic           ioctl_din_ok;
  logic           game_we = 1'b0;
  logic           dirty, busy, sel_b, we_b;
  logic [AW-1:0]  addr1b;
  logic [DW-1:0]  data1;
  logic [DW-1:0]  q1;

  always #5 clk = ~clk;

  jtframe_nvram_ioctl #(
    .DW(DW), .AW(AW), .IOW(IOW), .RDLAT(RDLAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ioctl_ram(ioctl_ram),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din), .ioctl_din_ok(ioctl_din_ok),
    .game_we(game_we), .dirty(dirty), .busy(busy),
    .sel_b(sel_b), .addr1b(addr1b), .we_b(we_b),
    .data1(data1), .q1(q1)
  );

  // NVRAM port 1 model, with a preload port for the bench
  logic [DW-1:0] mem [DEPTH];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (we_b) mem[addr1b] <= data1;
    q1 <= mem[addr1b];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   at;
  } wexp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [31:0]   at;
  } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int unsigned free_cyc = 0;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: idle port accepts one strobe; a write occupies
  // it 1 cycle, a read RDLAT+1 cycles; data comes from ref_mem.
  task automatic strobe(input bit wr, input bit rd,
                        input logic [IOW-1:0] a,
                        input logic [DW-1:0] d);
    int unsigned n;
    bit inr;
    n   = cyc;
    inr = 32'(a) < DEPTH;
    ioctl_wr   = wr;
    ioctl_rd   = rd;
    ioctl_addr = a;
    ioctl_dout = d;
    if (ioctl_ram && n >= free_cyc && (wr || rd)) begin
      if (wr) begin
        if (inr) begin
          wq.push_back('{addr: a[AW-1:0], data: d, at: n + 1});
          ref_mem[a[AW-1:0]] = d;
        end
        free_cyc = n + 2;
      end else begin
        rq.push_back('{data: inr ? ref_mem[a[AW-1:0]] : '0,
                       at: n + 2 + RDLAT});
        free_cyc = n + 2 + RDLAT;
      end
    end
    tick();
    ioctl_wr = 1'b0;
    ioctl_rd = 1'b0;
  endtask

  task automatic wait_free();
    while (cyc < free_cyc) tick();
  endtask

  always @(negedge clk) begin
    wexp_t w;
    rexp_t r;
    if (rst_n) begin
      if (we_b) begin
        chk("we_b_sel_b", 32'(sel_b), 32'd1);
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL we_b_unexpected: got we_b=1 at cycle %0d, want none", cyc);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", 32'(addr1b), 32'(w.addr));
          chk("wr_data", 32'(data1), 32'(w.data));
          chk("wr_cycle", cyc, w.at);
        end
      end
      if (ioctl_din_ok) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL din_ok_unexpected: got din_ok=1 at cycle %0d, want none", cyc);
        end else begin
          r = rq.pop_front();
          chk("rd_data", 32'(ioctl_din), 32'(r.data));
          chk("rd_cycle", cyc, r.at);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int unsigned n0, op, gap, sel, mism;
    logic [IOW-1:0] a;

    for (int i = 0; i < int'(DEPTH); i++) begin
      pl_en   = 1'b1;
      pl_addr = AW'(i);
      pl_data = DW'($urandom);
      ref_mem[i] = pl_data;
      tick();
    end
    pl_en = 1'b0;

    chk("reset_ctrl", 32'({sel_b, we_b, ioctl_din_ok, dirty, busy}), 32'd0);
    chk("reset_bus", 32'({addr1b, data1}), 32'd0);
    chk("reset_din", 32'(ioctl_din), 32'd0);

    rst_n = 1'b1;
    tick();
    tick();
    chk("dirty_init", 32'(dirty), 32'd0);
    game_we = 1'b1;
    tick();
    game_we = 1'b0;
    chk("dirty_set", 32'(dirty), 32'd1);

    strobe(1'b1, 1'b0, IOW'('h021), 8'h11);
    chk("closed_drop_busy", 32'(busy), 32'd0);

    ioctl_ram = 1'b1;
    chk("sel_b_before_rise", 32'(sel_b), 32'd0);
    tick();
    chk("sel_b_rise", 32'(sel_b), 32'd1);

    strobe(1'b1, 1'b0, IOW'('h005), 8'hA5);
    wait_free();
    strobe(1'b1, 1'b0, IOW'('h3FF), 8'h3C);
    wait_free();
    strobe(1'b0, 1'b1, IOW'('h3FF), 8'h00);
    chk("busy_in_rd", 32'(busy), 32'd1);
    wait_free();
    strobe(1'b1, 1'b0, IOW'('h400), 8'h77);
    wait_free();
    strobe(1'b0, 1'b1, IOW'('h400), 8'h00);
    wait_free();
    strobe(1'b1, 1'b1, IOW'('h010), 8'h99);
    wait_free();
    strobe(1'b0, 1'b1, IOW'('h010), 8'h00);
    strobe(1'b0, 1'b1, IOW'('h011), 8'h00);
    wait_free();

    for (int i = 0; i < 300; i++) begin
      op  = $urandom_range(0, 3);
      sel = $urandom_range(0, 7);
      gap = $urandom_range(0, 3);
      if (sel == 0) a = IOW'($urandom) | IOW'(DEPTH);
      else a = IOW'($urandom_range(0, DEPTH - 1));
      strobe(op != 2, op >= 2, a, DW'($urandom));
      for (int g = 0; g < int'(gap); g++) tick();
    end
    wait_free();

    for (int i = 0; i < int'(DEPTH); i++) begin
      strobe(1'b0, 1'b1, IOW'(i), 8'h00);
      wait_free();
    end

    n0 = cyc;
    strobe(1'b0, 1'b1, IOW'('h123), 8'h00);
    ioctl_ram = 1'b0;
    tick();
    chk("edge_sel_n2", 32'(sel_b), 32'd1);
    tick();
    chk("edge_sel_n3", 32'(sel_b), 32'd1);
    chk("edge_cycle", cyc - n0, 32'd3);
    tick();
    chk("edge_sel_n4", 32'(sel_b), 32'd0);
    chk("dirty_cleared", 32'(dirty), 32'd0);
    chk("edge_busy", 32'(busy), 32'd0);

    ioctl_ram = 1'b1;
    tick();
    tick();
    strobe(1'b1, 1'b0, IOW'('h030), 8'h42);
    wait_free();
    ioctl_ram = 1'b0;
    game_we   = 1'b1;
    tick();
    game_we = 1'b0;
    tick();
    chk("dirty_game_wins", 32'(dirty), 32'd1);
    tick();
    tick();
    chk("dirty_game_hold", 32'(dirty), 32'd1);

    ioctl_ram = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    ioctl_ram = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("dirty_empty_window", 32'(dirty), 32'd1);

    for (int i = 0; i < 50 && (wq.size() + rq.size()) != 0; i++)
      tick();
    chk("queues_drained", 32'(wq.size() + rq.size()), 32'd0);

    ioctl_ram = 1'b1;
    tick();
    ioctl_addr = IOW'('h040);
    ioctl_dout = 8'hDD;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    chk("midwr_we_b", 32'(we_b), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_we_b", 32'(we_b), 32'd0);
    chk("rst_sel_b", 32'({sel_b, busy, dirty}), 32'd0);
    ioctl_ram = 1'b0;
    tick();
    tick();

    mism = 0;
    for (int i = 0; i < int'(DEPTH); i++)
      if (mem[i] !== ref_mem[i]) mism++;
    chk("ram_image", mism, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
